// File: rtl/cdec8_clock_sequencer_pkg.sv
// Package shared by the CDEC8 clock sequencer files.
// Holds the sequencer state encoding and the CDEC8 address width.
package cdec8_clock_sequencer_pkg;

  // CDEC8 program counter / breakpoint address width
  localparam int ADRS_W = 8;

  // Sequencer states; the numeric values are fixed so debug tools can decode them
  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/cdec8_clock_sequencer_button_debouncer.sv
// Step button conditioner: two-flop synchronizer, stability counter and
// falling-edge pulse generator.
// Ports:
//   clock       in   system clock, rising edge
//   reset_N     in   synchronous active-low reset
//   btn_in      in   raw asynchronous button, active low
//   level_out   out  debounced button level (1 = released)
//   press_pulse out  one-cycle pulse on a debounced 1->0 transition
module button_debouncer
  import cdec8_clock_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset_N,
  input  logic btn_in,
  output logic level_out,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          pulse_r;
  logic [CW-1:0] cnt_r;

  // Synchronizer, stability counter and registered press pulse
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      level_r <= 1'b1;
      pulse_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
      pulse_r <= 1'b0;
      if (sync2_r != level_r) begin
        // The sample that completes the run of differing samples flips the level
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
          pulse_r <= level_r & ~sync2_r;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        // A sample equal to the current level breaks the run
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign level_out   = level_r;
  assign press_pulse = pulse_r;

endmodule

// File: rtl/cdec8_clock_sequencer.sv
// CDEC8 CPU clock sequencer: derives cpu_clock from the system clock with
// single-step, free-run, breakpoint and halt-on-end-of-sequence operation.
// Ports:
//   clock       in   system clock, rising edge
//   reset_N     in   synchronous active-low reset
//   prog_mode   in   1 = program mode, CPU clock parked low
//   run_sw      in   1 = free-run, 0 = single-step
//   step_btn    in   raw step button, active low, asynchronous
//   endseq      in   CDEC8 end-of-sequence flag
//   bp_en       in   breakpoint enable
//   bp_adrs     in   breakpoint address
//   pc          in   CDEC8 program counter
//   cpu_clock   out  clock to CDEC8 / RAM
//   running     out  1 while in HI or LO
//   halted      out  1 in HALT
//   bp_hit      out  sticky: last stop caused by breakpoint
//   cycle_count out  cpu_clock rising edges since reset
module cdec8_clock_sequencer
  import cdec8_clock_sequencer_pkg::*;
#(
  parameter int PHASE_CYCLES    = 2500000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 16
) (
  input  logic              clock,
  input  logic              reset_N,
  input  logic              prog_mode,
  input  logic              run_sw,
  input  logic              step_btn,
  input  logic              endseq,
  input  logic              bp_en,
  input  logic [ADRS_W-1:0] bp_adrs,
  input  logic [ADRS_W-1:0] pc,
  output logic              cpu_clock,
  output logic              running,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_CYCLES - 1);

  seq_state_t       state_r;
  seq_state_t       state_next;
  logic [PW-1:0]    phase_r;
  logic [PW-1:0]    phase_next;
  logic             bp_hit_r;
  logic             bp_hit_next;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next;
  logic             cpu_clock_r;
  logic             running_r;
  logic             halted_r;
  logic             step_pulse;
  logic             btn_level;
  logic             phase_done;
  logic             bp_match;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock      (clock),
    .reset_N    (reset_N),
    .btn_in     (step_btn),
    .level_out  (btn_level),
    .press_pulse(step_pulse)
  );

  assign phase_done = (phase_r == {PW{1'b0}});
  assign bp_match   = bp_en & (pc == bp_adrs);

  // Next-state logic; step_pulse outside STOP simply has no effect
  always_comb begin
    state_next  = state_r;
    phase_next  = phase_r;
    bp_hit_next = bp_hit_r;
    count_next  = count_r;
    case (state_r)
      ST_STOP: begin
        if (step_pulse && !prog_mode) begin
          state_next  = ST_HI;
          phase_next  = PHASE_LAST;
          bp_hit_next = 1'b0;
          count_next  = count_r + CNT_W'(1);
        end else begin
          state_next = ST_STOP;
        end
      end
      ST_HI: begin
        if (phase_done) begin
          state_next = ST_LO;
          phase_next = PHASE_LAST;
        end else begin
          phase_next = phase_r - PW'(1);
        end
      end
      ST_LO: begin
        if (phase_done) begin
          // Mode inputs are only honoured here so a started period always completes
          phase_next = PHASE_LAST;
          if (prog_mode) begin
            state_next = ST_STOP;
          end else if (endseq) begin
            state_next = ST_HALT;
          end else if (bp_match) begin
            state_next  = ST_STOP;
            bp_hit_next = 1'b1;
          end else if (run_sw) begin
            state_next = ST_HI;
            count_next = count_r + CNT_W'(1);
          end else begin
            state_next = ST_STOP;
          end
        end else begin
          phase_next = phase_r - PW'(1);
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_STOP;
        phase_next = {PW{1'b0}};
      end
    endcase
  end

  // State, counters and registered decode of the outputs from the next state
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state_r     <= ST_STOP;
      phase_r     <= {PW{1'b0}};
      bp_hit_r    <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
      cpu_clock_r <= 1'b0;
      running_r   <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_next;
      phase_r     <= phase_next;
      bp_hit_r    <= bp_hit_next;
      count_r     <= count_next;
      cpu_clock_r <= (state_next == ST_HI);
      running_r   <= (state_next == ST_HI) || (state_next == ST_LO);
      halted_r    <= (state_next == ST_HALT);
    end
  end

  assign cpu_clock   = cpu_clock_r;
  assign running     = running_r;
  assign halted      = halted_r;
  assign bp_hit      = bp_hit_r;
  assign cycle_count = count_r;

endmodule

// File: doc/cdec8_clock_sequencer.md
Name: cdec8_clock_sequencer

Overview:
Generates the CDEC8 CPU clock (`cpu_clock`) from the board system clock.
- Supports single-step, free-run, breakpoint and halt-on-end-of-sequence operation.
- Sits in the board shell between the push button/slide switches and the CPU core/RAM clock mux.
- Replaces driving the CPU clock directly from a raw button.
- Internally debounces the step button and counts executed CPU cycles for the debug display.

Parameters:
- PHASE_CYCLES, 2500000: system clocks per cpu_clock half-period in free-run (10 Hz at 50 MHz); must be ≥1.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a new button level; must be ≥1.
- CNT_W, 16: width of cycle_count.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_N  in  1  synchronous active-low reset.
- prog_mode  in  1  1 = program mode; CPU clock is parked low.
- run_sw  in  1  1 = free-run after start; 0 = single-step.
- step_btn  in  1  raw push button, active low (pressed = 0), asynchronous.
- endseq  in  1  CDEC8 end-of-sequence flag.
- bp_en  in  1  breakpoint enable.
- bp_adrs  in  8  breakpoint address.
- pc  in  8  current CDEC8 program counter.
- cpu_clock  out  1  clock to CDEC8 and to the RAM in run mode.
- running  out  1  1 while in HI or LO.
- halted  out  1  1 in HALT.
- bp_hit  out  1  sticky flag: last stop was caused by the breakpoint.
- cycle_count  out  CNT_W  cpu_clock rising edges since reset.

Behaviour:
- Reset (reset_N=0 at a clock edge) forces:
  - state STOP, cpu_clock=0, running=0, halted=0, bp_hit=0, cycle_count=0;
  - phase counter 0, synchronizer flops and debounced level = 1 (released).
- Reset mid-HI drops cpu_clock to 0 on the same edge.
- Button path:
  - 2-flop synchronizer, then stability counter.
  - The debounced level takes the synchronized value after DEBOUNCE_CYCLES consecutive identical samples that differ from it. Any mismatch restarts the count.
  - step_pulse is a one-cycle pulse on a debounced 1→0 transition.
  - Latency from a stable press to step_pulse = 2 + DEBOUNCE_CYCLES clocks.
- State machine, `state` encoded as 2 bits:
  - STOP: cpu_clock=0. On step_pulse with prog_mode=0 → HI, clear bp_hit, load phase counter. Stays in STOP otherwise. step_pulse is ignored while prog_mode=1.
  - HI: cpu_clock=1. Entering HI increments cycle_count, wrapping all-ones→0. After PHASE_CYCLES clocks in HI → LO.
  - LO: cpu_clock=0 for PHASE_CYCLES clocks. On the last LO cycle, the first matching rule applies:
    1. prog_mode=1 → STOP;
    2. endseq=1 → HALT;
    3. bp_en=1 and pc==bp_adrs → STOP, set bp_hit;
    4. run_sw=1 → HI;
    5. otherwise → STOP.
  - HALT: cpu_clock=0. Exited only by reset; step_pulse is ignored.
- cpu_clock is a registered state decode: glitch-free, no combinational path from inputs.
- A started CPU period always completes: prog_mode or run_sw changing during HI/LO takes effect only at the end of LO.
- step_pulse arriving in HI/LO is dropped, not queued.
- running = (state==HI || state==LO); halted = (state==HALT).
- In single-step mode each press yields exactly one cpu_clock period of 2×PHASE_CYCLES clocks.
- After a breakpoint stop, run resumes only on a new step_pulse. pc is rechecked after that period, so a loop re-hits the breakpoint each pass.

Decomposition:
- Shared package holds:
  - state encoding constants: STOP=2'd0, HI=2'd1, LO=2'd2, HALT=2'd3;
  - the 8-bit address width constant used by CDEC8.
- One sub-module: `button_debouncer` (synchronizer + stability counter + falling-edge pulse; parameter DEBOUNCE_CYCLES; ports clock, reset_N, btn_in, level_out, press_pulse).
- The top holds the FSM, phase counter and cycle counter.

Test Plan:
Bench parameters: PHASE_CYCLES=4, DEBOUNCE_CYCLES=3.
1. Single step:
   - Stimulus: run_sw=0; step_btn held low 10 clocks, then high.
   - Response: exactly one cpu_clock high pulse of 4 clocks followed by 4 low; cycle_count 0→1; back in STOP.
2. Bounce rejection:
   - Stimulus: step_btn toggles every clock for 8 clocks, then settles low.
   - Response: exactly one step_pulse, 5 clocks after settling; one CPU period.
3. Free-run and breakpoint:
   - Stimulus: run_sw=1, bp_en=1, bp_adrs=8'h05; bench increments pc on each cpu_clock rise starting at 0; one press.
   - Response: cpu_clock periodic with period 8; stops in STOP after the period where pc==8'h05; bp_hit=1; cycle_count=5.
4. Halt:
   - Stimulus: free-run; endseq raised during the 3rd HI phase.
   - Response: enters HALT at end of that LO; cpu_clock=0; further presses ignored; only reset_N=0 clears halted.
5. Mode switch and reset mid-operation:
   - Stimulus: prog_mode=1 asserted in the middle of a HI phase.
   - Response: HI/LO complete (4+4 clocks), then STOP; presses ignored while prog_mode=1.
   - Stimulus: reset_N=0 during HI.
   - Response: cpu_clock=0 and cycle_count=0 on the next edge.
6. Counter wrap:
   - Stimulus: CNT_W=4; 17 single steps.
   - Response: cycle_count reads 1 (wrapped 15→0→1).
